// File: rtl/dm_pkg.sv
// Shared types, widths and helpers for the data-memory responder.
package dm_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWait   = 2'd1,
      StAccess = 2'd2,
      StResp   = 2'd3
   } dm_state_e;

   localparam int unsigned BeWidth   = 4;
   localparam int unsigned WordWidth = 32;

   // Misaligned or beyond the last word of a 2**depth_log2-word array.
   function automatic logic dm_addr_err(input logic [WordWidth-1:0] addr,
                                        input int unsigned          depth_log2);
      logic [WordWidth:0] lim;
      lim = {{WordWidth{1'b0}}, 1'b1} << depth_log2;
      return (addr[1:0] != 2'b00) || ({3'b000, addr[WordWidth-1:2]} >= lim);
   endfunction

   function automatic logic [WordWidth-1:0] dm_be_merge(input logic [WordWidth-1:0] old_word,
                                                        input logic [WordWidth-1:0] wdata,
                                                        input logic [BeWidth-1:0]   be);
      logic [WordWidth-1:0] merged;
      merged = old_word;
      for (int i = 0; i < BeWidth; i++) begin
         if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dm_word_array.sv
// Word array with synchronous byte-enabled write and combinational read; contents are not reset.
module dm_word_array
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic [BeWidth-1:0]    i_be,
   input  logic [WordWidth-1:0]  i_wdata,
   output logic [WordWidth-1:0]  o_rdata
);

   logic [WordWidth-1:0] r_mem [2**DEPTH_LOG2];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int i = 0; i < BeWidth; i++) begin
            if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, access, valid/ready response.
// Define DM_TRACE_EN to print every committed write.
module dm_responder
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [WordWidth-1:0] req_addr,
   input  logic [BeWidth-1:0]   req_be,
   input  logic [WordWidth-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WordWidth-1:0] rsp_rdata,
   output logic                 rsp_err
);

   dm_state_e             r_state, w_state_nxt;
   logic [3:0]            r_cnt, w_cnt_nxt;
   logic                  r_we;
   logic [WordWidth-1:0]  r_addr;
   logic [BeWidth-1:0]    r_be;
   logic [WordWidth-1:0]  r_wdata;
   logic [WordWidth-1:0]  r_rdata, w_rdata_nxt;
   logic                  r_err, w_err_nxt;

   logic                  w_accept;
   logic                  w_addr_err;
   logic                  w_mem_we;
   logic [DEPTH_LOG2-1:0] w_word_idx;
   logic [WordWidth-1:0]  w_mem_rdata;

   assign w_accept   = req_valid && (r_state == StIdle);
   assign w_addr_err = dm_addr_err(r_addr, DEPTH_LOG2);
   assign w_word_idx = r_addr[DEPTH_LOG2+1:2];
   assign w_mem_we   = (r_state == StAccess) && r_we && !w_addr_err;

   assign req_ready = (r_state == StIdle);
   assign rsp_valid = (r_state == StResp);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   dm_word_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .i_clk  (clk),
      .i_we   (w_mem_we),
      .i_addr (w_word_idx),
      .i_be   (r_be),
      .i_wdata(r_wdata),
      .o_rdata(w_mem_rdata)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = r_err;
      unique case (r_state)
         StIdle: begin
            if (req_valid) begin
               w_cnt_nxt   = WAIT_CYCLES[3:0];
               w_state_nxt = (WAIT_CYCLES != 0) ? StWait : StAccess;
            end
         end
         StWait: begin
            // Leaves after exactly WAIT_CYCLES cycles in this state.
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_state_nxt = StAccess;
         end
         StAccess: begin
            w_err_nxt   = w_addr_err;
            w_rdata_nxt = (w_addr_err || r_we) ? '0 : w_mem_rdata;
            w_state_nxt = StResp;
         end
         StResp: begin
            if (rsp_ready) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rdata <= w_rdata_nxt;
         r_err   <= w_err_nxt;
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_be    <= req_be;
            r_wdata <= req_wdata;
         end
      end
   end

`ifdef DM_TRACE_EN
   logic [WordWidth-1:0] w_merged;
   assign w_merged = dm_be_merge(w_mem_rdata, r_wdata, r_be);

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         $write("%0t ", $time);
         $display("@%h: *%h <= %h", r_addr, {r_addr[WordWidth-1:2], 2'b00}, w_merged);
      end
   end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: scoreboarded transactions on a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance.
module tb_dm_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_valid0 = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;

   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        req_ready0, rsp_valid0, rsp_err0;
   logic [31:0] rsp_rdata0;

   int checks = 0;
   int errs   = 0;

   logic [32:0] exp_q[$];
   logic [31:0] mem_m [2][1024];

   always #5 clk = ~clk;

   dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // One full transaction; hold>0 keeps rsp_ready low for that many RESP cycles.
   task automatic xact(input int sel, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, input int hold,
                       input int exp_lat, input string tag);
      logic        e;
      logic [31:0] w;
      logic [32:0] ex;
      int          n;
      int          lat;
      e = (addr[1:0] != 2'b00) || (addr >= 32'h0000_1000);
      w = 32'h0;
      if (!e) begin
         if (we) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) mem_m[sel][addr[11:2]][8*i +: 8] = wd[8*i +: 8];
         end else begin
            w = mem_m[sel][addr[11:2]];
         end
      end
      exp_q.push_back({e, w});

      @(negedge clk);
      req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
      rsp_ready = (hold == 0);
      if (sel == 0) req_valid = 1'b1; else req_valid0 = 1'b1;
      n = 0;
      while (!((sel == 0) ? req_ready : req_ready0) && n < 50) begin
         @(negedge clk); n++;
      end
      chk({tag, "/accept"}, {31'b0, (sel == 0) ? req_ready : req_ready0}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0; req_valid0 = 1'b0;
      req_wdata = ~wd; req_addr = addr ^ 32'h4; // later changes must be ignored
      lat = 1;
      while (!((sel == 0) ? rsp_valid : rsp_valid0) && lat < 40) begin
         @(negedge clk); lat++;
      end
      chk({tag, "/latency"}, lat, exp_lat);
      ex = exp_q.pop_front();
      chk({tag, "/rdata"}, (sel == 0) ? rsp_rdata : rsp_rdata0, ex[31:0]);
      chk({tag, "/err"}, {31'b0, (sel == 0) ? rsp_err : rsp_err0}, {31'b0, ex[32]});
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            chk({tag, "/bp_valid"}, {31'b0, rsp_valid}, 32'd1);
            chk({tag, "/bp_rdata"}, rsp_rdata, ex[31:0]);
            chk({tag, "/bp_err"}, {31'b0, rsp_err}, {31'b0, ex[32]});
            chk({tag, "/bp_req_ready"}, {31'b0, req_ready}, 32'd0);
         end
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, "/done_valid"}, {31'b0, (sel == 0) ? rsp_valid : rsp_valid0}, 32'd0);
      chk({tag, "/done_ready"}, {31'b0, (sel == 0) ? req_ready : req_ready0}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset held for 3 cycles
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst/req_ready", {31'b0, req_ready}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("idle/req_ready", {31'b0, req_ready}, 32'd1);
      chk("idle/rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("idle/rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("idle/rsp_rdata", rsp_rdata, 32'd0);

      xact(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 4, "wr10");
      xact(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, 4, "rd10");
      xact(0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, 0, 4, "pwr10");
      xact(0, 1'b0, 32'h10, 4'hF, 32'h0, 0, 4, "prd10");
      xact(0, 1'b0, 32'h12, 4'hF, 32'h0, 0, 4, "rd_misal");
      xact(0, 1'b1, 32'h0, 4'hF, 32'h0BAD_CAFE, 0, 4, "wr0");
      xact(0, 1'b1, 32'h1000, 4'hF, 32'h1234_5678, 0, 4, "wr_oob");
      xact(0, 1'b0, 32'h0, 4'hF, 32'h0, 0, 4, "rd0_after_oob");
      xact(0, 1'b1, 32'h0, 4'h0, 32'hFFFF_FFFF, 0, 4, "wr0_be0");
      xact(0, 1'b0, 32'h0, 4'hF, 32'h0, 0, 4, "rd0_after_be0");
      xact(0, 1'b1, 32'hFFC, 4'hF, 32'hA5A5_5A5A, 0, 4, "wr_last");
      xact(0, 1'b0, 32'hFFC, 4'hF, 32'h0, 0, 4, "rd_last");
      xact(0, 1'b0, 32'h10, 4'hF, 32'h0, 5, 4, "rd_bp");

      // Reset during WAIT of a write must drop the write.
      xact(0, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 0, 4, "wr20");
      xact(0, 1'b0, 32'h20, 4'hF, 32'h0, 0, 4, "rd20");
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h5555_5555;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort/in_wait", {31'b0, req_ready}, 32'd0);
      #1 reset = 1'b0;
      #1;
      chk("abort/req_ready", {31'b0, req_ready}, 32'd1);
      chk("abort/rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("abort/rsp_rdata", rsp_rdata, 32'd0);
      chk("abort/rsp_err", {31'b0, rsp_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      xact(0, 1'b0, 32'h20, 4'hF, 32'h0, 0, 4, "rd20_after_abort");

      // Zero wait states on the second instance
      xact(1, 1'b1, 32'h40, 4'hF, 32'h0102_0304, 0, 2, "w0_wr40");
      xact(1, 1'b0, 32'h40, 4'hF, 32'h0, 0, 2, "w0_rd40");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
